// File: rtl/mmio_hs_controller.sv
// mmio_hs_controller
//   Bridges the CPU-side MMIO bus to N_SLOT peripheral slots. Each access is
//   decoded into a slot number and a register address. The slot strobes stay
//   high until the addressed slot answers with ready. If the slot never answers,
//   the access is aborted after TIMEOUT wait cycles. Illegal requests (read and
//   write together) and aborted accesses come back with mmio_err set and
//   ERR_DATA as the read data.
//
// Ports
//   clk, reset                    clock and asynchronous active-high reset
//   mmio_cs/rd/wr/addr/wr_data    CPU request; cs is a one-cycle strobe
//   mmio_rd_data                  registered read data, held until the next response
//   mmio_ready, mmio_err          one-cycle response pulse and its error qualifier
//   mmio_busy                     controller is handling an access
//   err_count                     saturating count of errored responses
//   slot_cs/mem_rd/mem_wr_array   per-slot select and strobes (addressed slot only)
//   slot_reg_addr/wr_data_array   latched register address and write data, broadcast
//   slot_rd_data/ready_array      per-slot read data and completion handshake

module mmio_hs_controller #(
  parameter int          N_SLOT   = 64,
  parameter int          REG_AW   = 5,
  parameter int          ADDR_W   = 21,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          mmio_cs,
  input  logic                          mmio_wr,
  input  logic                          mmio_rd,
  input  logic [ADDR_W-1:0]             mmio_addr,
  input  logic [31:0]                   mmio_wr_data,
  output logic [31:0]                   mmio_rd_data,
  output logic                          mmio_ready,
  output logic                          mmio_err,
  output logic                          mmio_busy,
  output logic [15:0]                   err_count,
  output logic [N_SLOT-1:0]             slot_cs_array,
  output logic [N_SLOT-1:0]             slot_mem_rd_array,
  output logic [N_SLOT-1:0]             slot_mem_wr_array,
  output logic [N_SLOT-1:0][REG_AW-1:0] slot_reg_addr_array,
  output logic [N_SLOT-1:0][31:0]       slot_wr_data_array,
  input  logic [N_SLOT-1:0][31:0]       slot_rd_data_array,
  input  logic [N_SLOT-1:0]             slot_ready_array
);

  localparam int SLOT_W = $clog2(N_SLOT);
  // The counter only has to reach TIMEOUT-1, so $clog2(TIMEOUT) bits suffice.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e              state_q;
  logic [SLOT_W-1:0]   slot_q;
  logic [REG_AW-1:0]   reg_q;
  logic [31:0]         wdata_q;
  logic                is_rd_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [31:0]         rdata_q;
  logic                ready_q;
  logic                err_q;
  logic                busy_q;
  logic [15:0]         err_count_q;
  logic [15:0]         err_count_d;
  logic [N_SLOT-1:0]   cs_q;
  logic [N_SLOT-1:0]   rd_q;
  logic [N_SLOT-1:0]   wr_q;

  logic [SLOT_W-1:0]   addr_slot;
  logic [REG_AW-1:0]   addr_reg;
  logic [N_SLOT-1:0]   addr_onehot;
  logic                req_valid;
  logic                req_illegal;
  logic                sel_ready;
  logic [31:0]         sel_rdata;
  logic                timeout_hit;

  // Address bits above the slot field carry no meaning for this controller.
  generate
    if (ADDR_W > REG_AW + SLOT_W) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^mmio_addr[ADDR_W-1:REG_AW+SLOT_W];
    end
  endgenerate

  // Request decode: split the address and classify the request.
  assign addr_slot   = mmio_addr[REG_AW+SLOT_W-1:REG_AW];
  assign addr_reg    = mmio_addr[REG_AW-1:0];
  assign addr_onehot = {{(N_SLOT-1){1'b0}}, 1'b1} << addr_slot;
  assign req_valid   = mmio_cs & (mmio_rd ^ mmio_wr);
  assign req_illegal = mmio_cs & mmio_rd & mmio_wr;

  // Only the latched slot's handshake and read data matter while waiting.
  assign sel_ready = slot_ready_array[slot_q];
  assign sel_rdata = slot_rd_data_array[slot_q];

  // A TIMEOUT of zero disables the abort entirely.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  // The error counter sticks at all-ones instead of wrapping.
  assign err_count_d = (err_count_q == 16'hFFFF) ? err_count_q : err_count_q + 16'd1;

  // Main FSM with all bus-facing outputs registered. Strobes are set on the
  // accepting edge and cleared on the edge that moves to RESP, so that a slot
  // sees them for the whole wait. The response pulse is produced while in RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      slot_q      <= '0;
      reg_q       <= '0;
      wdata_q     <= '0;
      is_rd_q     <= 1'b0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      err_count_q <= '0;
      cs_q        <= '0;
      rd_q        <= '0;
      wr_q        <= '0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            slot_q  <= addr_slot;
            reg_q   <= addr_reg;
            wdata_q <= mmio_wr_data;
            is_rd_q <= mmio_rd;
            cnt_q   <= '0;
            cs_q    <= addr_onehot;
            rd_q    <= mmio_rd ? addr_onehot : '0;
            wr_q    <= mmio_wr ? addr_onehot : '0;
            busy_q  <= 1'b1;
            state_q <= WAIT;
          end else if (req_illegal) begin
            // No slot is touched; answer directly with an error.
            ready_q     <= 1'b1;
            err_q       <= 1'b1;
            rdata_q     <= ERR_DATA;
            err_count_q <= err_count_d;
            busy_q      <= 1'b1;
            state_q     <= RESP;
          end
        end

        WAIT: begin
          // Ready is checked first so a late answer still wins over the abort.
          if (sel_ready) begin
            cs_q    <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            ready_q <= 1'b1;
            if (is_rd_q) begin
              rdata_q <= sel_rdata;
            end
            state_q <= RESP;
          end else if (timeout_hit) begin
            cs_q        <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
            ready_q     <= 1'b1;
            err_q       <= 1'b1;
            rdata_q     <= ERR_DATA;
            err_count_q <= err_count_d;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        RESP: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mmio_rd_data        = rdata_q;
  assign mmio_ready          = ready_q;
  assign mmio_err            = err_q;
  assign mmio_busy           = busy_q;
  assign err_count           = err_count_q;
  assign slot_cs_array       = cs_q;
  assign slot_mem_rd_array   = rd_q;
  assign slot_mem_wr_array   = wr_q;
  assign slot_reg_addr_array = {N_SLOT{reg_q}};
  assign slot_wr_data_array  = {N_SLOT{wdata_q}};

endmodule

// File: tb/tb_mmio_hs_controller.sv
// tb_mmio_hs_controller
//   Directed scenarios for mmio_hs_controller with 8 slots and an 8-cycle
//   timeout. Inputs change and outputs are observed on the falling edge.

module tb_mmio_hs_controller;

  localparam int NS = 8;
  localparam int RA = 5;
  localparam int AW = 21;

  logic                  clk;
  logic                  reset;
  logic                  mmio_cs;
  logic                  mmio_wr;
  logic                  mmio_rd;
  logic [AW-1:0]         mmio_addr;
  logic [31:0]           mmio_wr_data;
  logic [31:0]           mmio_rd_data;
  logic                  mmio_ready;
  logic                  mmio_err;
  logic                  mmio_busy;
  logic [15:0]           err_count;
  logic [NS-1:0]         slot_cs_array;
  logic [NS-1:0]         slot_mem_rd_array;
  logic [NS-1:0]         slot_mem_wr_array;
  logic [NS-1:0][RA-1:0] slot_reg_addr_array;
  logic [NS-1:0][31:0]   slot_wr_data_array;
  logic [NS-1:0][31:0]   slot_rd_data_array;
  logic [NS-1:0]         slot_ready_array;

  int checks;
  int errors;

  mmio_hs_controller #(
    .N_SLOT  (NS),
    .REG_AW  (RA),
    .ADDR_W  (AW),
    .TIMEOUT (8),
    .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .mmio_cs            (mmio_cs),
    .mmio_wr            (mmio_wr),
    .mmio_rd            (mmio_rd),
    .mmio_addr          (mmio_addr),
    .mmio_wr_data       (mmio_wr_data),
    .mmio_rd_data       (mmio_rd_data),
    .mmio_ready         (mmio_ready),
    .mmio_err           (mmio_err),
    .mmio_busy          (mmio_busy),
    .err_count          (err_count),
    .slot_cs_array      (slot_cs_array),
    .slot_mem_rd_array  (slot_mem_rd_array),
    .slot_mem_wr_array  (slot_mem_wr_array),
    .slot_reg_addr_array(slot_reg_addr_array),
    .slot_wr_data_array (slot_wr_data_array),
    .slot_rd_data_array (slot_rd_data_array),
    .slot_ready_array   (slot_ready_array)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a stuck simulation.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Drives a one-cycle request starting at the next falling edge and returns
  // on the following falling edge, when the first response cycle is visible.
  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [AW-1:0] addr, input logic [31:0] data);
    @(negedge clk);
    mmio_cs      = 1'b1;
    mmio_rd      = rd;
    mmio_wr      = wr;
    mmio_addr    = addr;
    mmio_wr_data = data;
    @(negedge clk);
    mmio_cs = 1'b0;
    mmio_rd = 1'b0;
    mmio_wr = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (slot_cs_array !== 8'h00 || slot_mem_rd_array !== 8'h00 || slot_mem_wr_array !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_strobes got %h/%h/%h exp 00/00/00",
               slot_cs_array, slot_mem_rd_array, slot_mem_wr_array);
    end
    checks++;
    if (mmio_ready !== 1'b0 || mmio_err !== 1'b0 || mmio_busy !== 1'b0 ||
        mmio_rd_data !== 32'h0 || err_count !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got rdy=%b err=%b busy=%b data=%h cnt=%h exp all zero",
               mmio_ready, mmio_err, mmio_busy, mmio_rd_data, err_count);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_read_single();
    applyStimulus(1'b1, 1'b0, 21'h00003, 32'h0);
    checks++;
    if (slot_cs_array !== 8'h01 || slot_mem_rd_array !== 8'h01 || slot_mem_wr_array !== 8'h00) begin
      errors++;
      $display("[TB] FAIL read_strobes got %h/%h/%h exp 01/01/00",
               slot_cs_array, slot_mem_rd_array, slot_mem_wr_array);
    end
    checks++;
    if (slot_reg_addr_array[0] !== 5'd3 || slot_reg_addr_array[7] !== 5'd3) begin
      errors++;
      $display("[TB] FAIL read_reg_addr got %h/%h exp 03/03",
               slot_reg_addr_array[0], slot_reg_addr_array[7]);
    end
    checks++;
    if (mmio_busy !== 1'b1 || mmio_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL read_busy got busy=%b rdy=%b exp 1/0", mmio_busy, mmio_ready);
    end
    @(negedge clk);
    checks++;
    if (mmio_ready !== 1'b1 || mmio_err !== 1'b0 || mmio_rd_data !== 32'h1234_5678) begin
      errors++;
      $display("[TB] FAIL read_resp got rdy=%b err=%b data=%h exp 1/0/12345678",
               mmio_ready, mmio_err, mmio_rd_data);
    end
    checks++;
    if (slot_cs_array !== 8'h00 || slot_mem_rd_array !== 8'h00) begin
      errors++;
      $display("[TB] FAIL read_strobe_drop got %h/%h exp 00/00", slot_cs_array, slot_mem_rd_array);
    end
    @(negedge clk);
    checks++;
    if (mmio_ready !== 1'b0 || mmio_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL read_pulse_end got rdy=%b busy=%b exp 0/0", mmio_ready, mmio_busy);
    end
  endtask

  task automatic test_write_wait();
    slot_ready_array[2] = 1'b0;
    applyStimulus(1'b0, 1'b1, 21'h00040, 32'h0000_00A5);
    for (int i = 1; i <= 5; i++) begin
      checks++;
      if (slot_mem_wr_array !== 8'h04 || slot_cs_array !== 8'h04 || slot_mem_rd_array !== 8'h00 ||
          slot_wr_data_array[2] !== 32'hA5 || mmio_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL write_hold cycle %0d got wr=%h cs=%h rd=%h data=%h rdy=%b exp 04/04/00/000000a5/0",
                 i, slot_mem_wr_array, slot_cs_array, slot_mem_rd_array,
                 slot_wr_data_array[2], mmio_ready);
      end
      if (i == 5) slot_ready_array[2] = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (mmio_ready !== 1'b1 || mmio_err !== 1'b0 || slot_mem_wr_array !== 8'h00) begin
      errors++;
      $display("[TB] FAIL write_resp got rdy=%b err=%b wr=%h exp 1/0/00",
               mmio_ready, mmio_err, slot_mem_wr_array);
    end
    checks++;
    if (mmio_rd_data !== 32'h1234_5678 || slot_wr_data_array[2] !== 32'hA5) begin
      errors++;
      $display("[TB] FAIL write_data_hold got rd=%h wr=%h exp 12345678/000000a5",
               mmio_rd_data, slot_wr_data_array[2]);
    end
  endtask

  task automatic test_timeout();
    slot_ready_array[4] = 1'b0;
    applyStimulus(1'b1, 1'b0, 21'h00080, 32'h0);
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (slot_mem_rd_array !== 8'h10 || slot_cs_array !== 8'h10 || mmio_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL timeout_hold cycle %0d got rd=%h cs=%h rdy=%b exp 10/10/0",
                 i, slot_mem_rd_array, slot_cs_array, mmio_ready);
      end
      @(negedge clk);
    end
    checks++;
    if (slot_mem_rd_array !== 8'h00 || slot_cs_array !== 8'h00) begin
      errors++;
      $display("[TB] FAIL timeout_drop got rd=%h cs=%h exp 00/00", slot_mem_rd_array, slot_cs_array);
    end
    checks++;
    if (mmio_ready !== 1'b1 || mmio_err !== 1'b1 || mmio_rd_data !== 32'hDEAD_BEEF ||
        err_count !== 16'd1) begin
      errors++;
      $display("[TB] FAIL timeout_resp got rdy=%b err=%b data=%h cnt=%0d exp 1/1/deadbeef/1",
               mmio_ready, mmio_err, mmio_rd_data, err_count);
    end
    slot_ready_array[4] = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_illegal();
    slot_rd_data_array[0] = 32'h0BAD_F00D;
    applyStimulus(1'b1, 1'b1, 21'h00003, 32'h55);
    checks++;
    if (mmio_ready !== 1'b1 || mmio_err !== 1'b1 || err_count !== 16'd2 ||
        mmio_rd_data !== 32'hDEAD_BEEF) begin
      errors++;
      $display("[TB] FAIL illegal_resp got rdy=%b err=%b cnt=%0d data=%h exp 1/1/2/deadbeef",
               mmio_ready, mmio_err, err_count, mmio_rd_data);
    end
    checks++;
    if (slot_cs_array !== 8'h00 || slot_mem_rd_array !== 8'h00 || slot_mem_wr_array !== 8'h00) begin
      errors++;
      $display("[TB] FAIL illegal_no_strobe got %h/%h/%h exp 00/00/00",
               slot_cs_array, slot_mem_rd_array, slot_mem_wr_array);
    end
    slot_rd_data_array[0] = 32'h1234_5678;
    @(negedge clk);
  endtask

  task automatic test_drop_during_wait();
    slot_ready_array[1]   = 1'b0;
    slot_rd_data_array[1] = 32'hCAFE_0001;
    applyStimulus(1'b1, 1'b0, 21'h00022, 32'h0);
    mmio_cs      = 1'b1;
    mmio_wr      = 1'b1;
    mmio_addr    = 21'h00060;
    mmio_wr_data = 32'h7777_7777;
    @(negedge clk);
    mmio_cs = 1'b0;
    mmio_wr = 1'b0;
    checks++;
    if (slot_cs_array !== 8'h02 || slot_mem_rd_array !== 8'h02 || slot_mem_wr_array !== 8'h00 ||
        slot_reg_addr_array[1] !== 5'd2) begin
      errors++;
      $display("[TB] FAIL drop_keep got cs=%h rd=%h wr=%h reg=%h exp 02/02/00/02",
               slot_cs_array, slot_mem_rd_array, slot_mem_wr_array, slot_reg_addr_array[1]);
    end
    slot_ready_array[1] = 1'b1;
    @(negedge clk);
    checks++;
    if (mmio_ready !== 1'b1 || mmio_err !== 1'b0 || mmio_rd_data !== 32'hCAFE_0001) begin
      errors++;
      $display("[TB] FAIL drop_resp got rdy=%b err=%b data=%h exp 1/0/cafe0001",
               mmio_ready, mmio_err, mmio_rd_data);
    end
    @(negedge clk);
    checks++;
    if (mmio_ready !== 1'b0 || slot_cs_array !== 8'h00 || mmio_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drop_not_queued got rdy=%b cs=%h busy=%b exp 0/00/0",
               mmio_ready, slot_cs_array, mmio_busy);
    end
  endtask

  task automatic test_back_to_back();
    applyStimulus(1'b1, 1'b0, 21'h00003, 32'h0);
    @(negedge clk);
    // Request issued during the response cycle must be ignored.
    mmio_cs   = 1'b1;
    mmio_wr   = 1'b1;
    mmio_addr = 21'h00060;
    checks++;
    if (mmio_ready !== 1'b1 || mmio_rd_data !== 32'h1234_5678) begin
      errors++;
      $display("[TB] FAIL b2b_first got rdy=%b data=%h exp 1/12345678", mmio_ready, mmio_rd_data);
    end
    @(negedge clk);
    checks++;
    if (slot_cs_array !== 8'h00 || mmio_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_resp_drop got cs=%h busy=%b exp 00/0", slot_cs_array, mmio_busy);
    end
    // Earliest legal follow-up request.
    mmio_wr   = 1'b0;
    mmio_rd   = 1'b1;
    mmio_addr = 21'h00003;
    @(negedge clk);
    mmio_cs = 1'b0;
    mmio_rd = 1'b0;
    checks++;
    if (slot_cs_array !== 8'h01 || slot_mem_rd_array !== 8'h01) begin
      errors++;
      $display("[TB] FAIL b2b_second got cs=%h rd=%h exp 01/01", slot_cs_array, slot_mem_rd_array);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_wait();
    slot_ready_array[5] = 1'b0;
    applyStimulus(1'b1, 1'b0, 21'h000A0, 32'h0);
    checks++;
    if (slot_cs_array !== 8'h20) begin
      errors++;
      $display("[TB] FAIL rst_pre got cs=%h exp 20", slot_cs_array);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (slot_cs_array !== 8'h00 || slot_mem_rd_array !== 8'h00 || mmio_busy !== 1'b0 ||
        err_count !== 16'h0 || mmio_rd_data !== 32'h0) begin
      errors++;
      $display("[TB] FAIL rst_async got cs=%h rd=%h busy=%b cnt=%h data=%h exp 00/00/0/0000/0",
               slot_cs_array, slot_mem_rd_array, mmio_busy, err_count, mmio_rd_data);
    end
    @(negedge clk);
    reset = 1'b0;
    slot_ready_array[5] = 1'b1;
    applyStimulus(1'b1, 1'b0, 21'h00003, 32'h0);
    checks++;
    if (slot_cs_array !== 8'h01) begin
      errors++;
      $display("[TB] FAIL rst_idle_accept got cs=%h exp 01", slot_cs_array);
    end
    @(negedge clk);
    checks++;
    if (mmio_ready !== 1'b1 || mmio_rd_data !== 32'h1234_5678) begin
      errors++;
      $display("[TB] FAIL rst_after_read got rdy=%b data=%h exp 1/12345678", mmio_ready, mmio_rd_data);
    end
  endtask

  task automatic test_saturation();
    @(negedge clk);
    force dut.err_count_q = 16'hFFFE;
    #1;
    release dut.err_count_q;
    applyStimulus(1'b1, 1'b1, 21'h0, 32'h0);
    checks++;
    if (err_count !== 16'hFFFF || mmio_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sat_reach got cnt=%h err=%b exp ffff/1", err_count, mmio_err);
    end
    applyStimulus(1'b1, 1'b1, 21'h0, 32'h0);
    checks++;
    if (err_count !== 16'hFFFF || mmio_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sat_hold got cnt=%h err=%b exp ffff/1", err_count, mmio_err);
    end
  endtask

  initial begin
    checks                = 0;
    errors                = 0;
    reset                 = 1'b1;
    mmio_cs               = 1'b0;
    mmio_rd               = 1'b0;
    mmio_wr               = 1'b0;
    mmio_addr             = '0;
    mmio_wr_data          = '0;
    slot_ready_array      = '1;
    slot_rd_data_array    = '0;
    slot_rd_data_array[0] = 32'h1234_5678;

    test_reset();
    test_read_single();
    test_write_wait();
    test_timeout();
    test_illegal();
    test_drop_during_wait();
    test_back_to_back();
    test_reset_mid_wait();
    test_saturation();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
